// File: rtl/uart_tx_fifo_if.sv
// Host-side write port of the FIFO-buffered UART transmitter.
// The host (master) queues words; the transmitter (slave) reports occupancy and status.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] data_i;
    logic                 start;
    logic                 waitflg;
    logic                 full_o;
    logic [LW-1:0]        level_o;
    logic                 overflow_o;

    modport master (
        output data_i,
        output start,
        input  waitflg,
        input  full_o,
        input  level_o,
        input  overflow_o
    );

    modport slave (
        input  data_i,
        input  start,
        output waitflg,
        output full_o,
        output level_o,
        output overflow_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: configurable width, parity and stop bits.
// Queued words are sent back-to-back; the next word is popped at the final stop-bit edge.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_fifo_if.slave host,
    output logic          signal_o
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned BW = 4;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [LW-1:0] DEPTH     = LW'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        count_q, count_d;
    logic                 full_q, waitflg_q, ovf_q;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] head_c;
    logic                 baud_end_c;
    logic                 pop_c, push_c;

    assign head_c     = mem[rd_ptr_q];
    assign baud_end_c = (baud_q == BAUD_LAST);

    // Next-state, FIFO handshake and next line level
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        pop_c   = 1'b0;
        push_c  = 1'b0;
        count_d = count_q;
        line_d  = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop_c = 1'b1;
                end
            end
            S_START: begin
                if (baud_end_c) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_end_c) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_end_c) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (baud_end_c) begin
                    if (bit_q == STOP_LAST) begin
                        if (count_q != '0) begin
                            pop_c = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            baud_d = baud_end_c ? '0 : baud_q + 1'b1;
        end

        // Popping always starts a fresh frame, whether from IDLE or straight out of STOP
        if (pop_c) begin
            state_d = S_START;
            baud_d  = '0;
            bit_d   = '0;
            shreg_d = head_c;
            par_d   = (PARITY == 1) ? ~(^head_c) : ^head_c;
        end

        push_c  = host.start && ((count_q != DEPTH) || pop_c);
        count_d = count_q + LW'(push_c) - LW'(pop_c);

        case (state_d)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shreg_d[0];
            S_PARITY: line_d = par_d;
            default:  line_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            line_q    <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            waitflg_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            line_q    <= line_d;
            wr_ptr_q  <= wr_ptr_q + PW'(push_c);
            rd_ptr_q  <= rd_ptr_q + PW'(pop_c);
            count_q   <= count_d;
            full_q    <= (count_d == DEPTH);
            waitflg_q <= (count_d != '0) || (state_d != S_IDLE);
            ovf_q     <= host.start && !push_c;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid
    always_ff @(posedge CLK) begin
        if (!RST && push_c) begin
            mem[wr_ptr_q] <= host.data_i;
        end
    end

    assign signal_o        = line_q;
    assign host.waitflg    = waitflg_q;
    assign host.full_o     = full_q;
    assign host.level_o    = count_q;
    assign host.overflow_o = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations share clock, reset and write strobe;
// a line monitor decodes frames of the selected instance into a queue for scoring.
module tb_uart_tx_fifo;
    localparam int unsigned CPB = 4;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       start = 1'b0;
    logic [8:0] din   = '0;
    logic       sig [4];
    logic       wf  [4];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] bits;
        time         t0;
        bit          ok;
    } rx_t;

    rx_t        rxq[$];
    logic [8:0] sb[$];
    int         mon_sel  = 0;
    int         mon_bits = 10;

    always #5 CLK = ~CLK;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if2 ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if3 ();

    assign if0.start = start;  assign if0.data_i = din[7:0];
    assign if1.start = start;  assign if1.data_i = din[7:0];
    assign if2.start = start;  assign if2.data_i = din[7:0];
    assign if3.start = start;  assign if3.data_i = din[6:0];
    assign wf[0] = if0.waitflg;
    assign wf[1] = if1.waitflg;
    assign wf[2] = if2.waitflg;
    assign wf[3] = if3.waitflg;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u0 (.CLK(CLK), .RST(RST), .host(if0), .signal_o(sig[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        u1 (.CLK(CLK), .RST(RST), .host(if1), .signal_o(sig[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        u2 (.CLK(CLK), .RST(RST), .host(if2), .signal_o(sig[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
        u3 (.CLK(CLK), .RST(RST), .host(if3), .signal_o(sig[3]));

    // Expected serial sequence, bit i is the i-th bit on the line
    function automatic logic [11:0] frame_bits(input logic [8:0] w, input int dbits, input int par);
        logic [11:0] f = '1;
        int          n = 1;
        logic        ones = 1'b0;
        f[0] = 1'b0;
        for (int i = 0; i < dbits; i++) begin
            f[n] = w[i];
            ones ^= w[i];
            n++;
        end
        if (par == 1) f[n] = ~ones;
        else if (par == 2) f[n] = ones;
        return f;
    endfunction

    function automatic logic [11:0] mask(input int nb);
        logic [11:0] m = '0;
        for (int i = 0; i < nb; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Line monitor: each bit must hold for CPB samples; frames cut by reset are discarded
    initial begin : monitor
        rx_t r;
        bit  ab;
        forever begin
            @(negedge CLK);
            if (!RST && sig[mon_sel] === 1'b0) begin
                r.t0 = $time; r.ok = 1'b1; r.bits = '1; ab = 1'b0;
                for (int b = 0; b < mon_bits; b++) begin
                    for (int c = 0; c < int'(CPB); c++) begin
                        if (b != 0 || c != 0) begin
                            @(negedge CLK);
                            if (RST) ab = 1'b1;
                        end
                        if (c == 0) r.bits[b] = sig[mon_sel];
                        else if (sig[mon_sel] !== r.bits[b]) r.ok = 1'b0;
                    end
                end
                if (!ab) rxq.push_back(r);
            end
        end
    end

    task automatic push_words(input logic [8:0] w0, input logic [8:0] w1, input int n, output time tk);
        @(negedge CLK);
        for (int i = 0; i < n; i++) begin
            start = 1'b1;
            din   = (i == 0) ? w0 : w1;
            @(posedge CLK);
            if (i == 0) tk = $time;
            @(negedge CLK);
        end
        start = 1'b0;
    endtask

    task automatic wait_rx(output rx_t r, output bit got);
        int n = 0;
        while (rxq.size() == 0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        got = (rxq.size() != 0);
        if (got) r = rxq.pop_front();
        else begin r.bits = '0; r.t0 = 0; r.ok = 1'b0; end
    endtask

    task automatic wait_all_idle(input string tag);
        int n = 0;
        while ((wf[0] | wf[1] | wf[2] | wf[3]) !== 1'b0 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            failures++;
            $display("FAIL %s_idle_timeout waitflg=%b%b%b%b expected 0000", tag, wf[0], wf[1], wf[2], wf[3]);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            if (i == 2) RST = 1'b0;
            checks++;
            if (sig[0] !== 1'b1 || if0.waitflg !== 1'b0 || if0.level_o !== 3'd0 ||
                if0.full_o !== 1'b0 || if0.overflow_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_state cycle=%0d line=%b wait=%b level=%0d full=%b ovf=%b expected 1 0 0 0 0",
                         i, sig[0], if0.waitflg, if0.level_o, if0.full_o, if0.overflow_o);
            end
        end
    endtask

    task automatic test_single;
        time        tk;
        rx_t        r;
        bit         got;
        int         busy = 0;
        logic [8:0] w;
        logic [11:0] e;
        mon_sel = 0; mon_bits = 10; rxq.delete(); sb.delete();
        push_words(9'h0AA, 9'h000, 1, tk);
        sb.push_back(9'h0AA);
        checks++;
        if (if0.level_o !== 3'd1 || if0.waitflg !== 1'b1) begin
            failures++;
            $display("FAIL single_accept level=%0d wait=%b expected 1 1", if0.level_o, if0.waitflg);
        end
        while (wf[0] === 1'b1 && busy < 500) begin
            busy++;
            @(negedge CLK);
        end
        checks++;
        if (busy != 41) begin
            failures++;
            $display("FAIL single_waitflg_len got=%0d expected 41", busy);
        end
        wait_rx(r, got);
        w = sb.pop_front();
        e = frame_bits(w, 8, 0);
        checks++;
        if (!got || !r.ok || (r.bits & mask(10)) !== (e & mask(10)) || r.t0 != tk + 15) begin
            failures++;
            $display("FAIL single_frame got=%b ok=%b bits=%b t0=%0t expected bits=%b t0=%0t",
                     got, r.ok, r.bits & mask(10), r.t0, e & mask(10), tk + 15);
        end
        wait_all_idle("single");
    endtask

    task automatic test_parity(input int sel, input int par);
        time         tk;
        rx_t         r;
        bit          got;
        int          busy = 0;
        logic [11:0] e;
        mon_sel = sel; mon_bits = 11; rxq.delete(); sb.delete();
        push_words(9'h007, 9'h000, 1, tk);
        sb.push_back(9'h007);
        while (wf[sel] === 1'b1 && busy < 500) begin
            busy++;
            @(negedge CLK);
        end
        checks++;
        if (busy != 45) begin
            failures++;
            $display("FAIL parity%0d_frame_len got=%0d expected 45", par, busy);
        end
        wait_rx(r, got);
        e = frame_bits(sb.pop_front(), 8, par);
        checks++;
        if (!got || !r.ok || (r.bits & mask(11)) !== (e & mask(11)) || r.t0 != tk + 15) begin
            failures++;
            $display("FAIL parity%0d_frame got=%b ok=%b bits=%b t0=%0t expected bits=%b t0=%0t",
                     par, got, r.ok, r.bits & mask(11), r.t0, e & mask(11), tk + 15);
        end
        wait_all_idle("parity");
    endtask

    task automatic test_back_to_back;
        int          exp_lv[6] = '{1, 1, 2, 3, 4, 4};
        int          exp_fl[6] = '{0, 0, 0, 0, 1, 1};
        int          exp_ov[6] = '{0, 0, 0, 0, 0, 1};
        int          ov_seen = 0;
        time         tk = 0;
        rx_t         r;
        bit          got;
        logic [11:0] e;
        mon_sel = 0; mon_bits = 10; rxq.delete(); sb.delete();
        @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            start = 1'b1;
            din   = 9'(i + 1);
            @(posedge CLK);
            if (i == 0) tk = $time;
            @(negedge CLK);
            if (exp_ov[i] == 0) sb.push_back(9'(i + 1));
            if (if0.overflow_o === 1'b1) ov_seen++;
            checks++;
            if (if0.level_o !== 3'(exp_lv[i]) || if0.full_o !== 1'(exp_fl[i]) ||
                if0.overflow_o !== 1'(exp_ov[i])) begin
                failures++;
                $display("FAIL burst_status write=%0d level=%0d full=%b ovf=%b expected %0d %0d %0d",
                         i + 1, if0.level_o, if0.full_o, if0.overflow_o, exp_lv[i], exp_fl[i], exp_ov[i]);
            end
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (if0.overflow_o === 1'b1) ov_seen++;
        end
        checks++;
        if (ov_seen != 1) begin
            failures++;
            $display("FAIL burst_overflow_pulses got=%0d expected 1", ov_seen);
        end
        for (int f = 0; f < 5; f++) begin
            wait_rx(r, got);
            e = frame_bits(sb.pop_front(), 8, 0);
            checks++;
            if (!got || !r.ok || (r.bits & mask(10)) !== (e & mask(10)) || r.t0 != tk + 15 + time'(f) * 400) begin
                failures++;
                $display("FAIL burst_frame%0d got=%b ok=%b bits=%b t0=%0t expected bits=%b t0=%0t",
                         f, got, r.ok, r.bits & mask(10), r.t0, e & mask(10), tk + 15 + time'(f) * 400);
            end
        end
        wait_all_idle("burst");
        checks++;
        if (rxq.size() != 0 || sb.size() != 0) begin
            failures++;
            $display("FAIL burst_leftover rx=%0d sb=%0d expected 0 0", rxq.size(), sb.size());
        end
    endtask

    task automatic test_two_stop;
        time         tk;
        time         t_first = 0;
        rx_t         r;
        bit          got;
        logic [11:0] e;
        mon_sel = 3; mon_bits = 10; rxq.delete(); sb.delete();
        push_words(9'h055, 9'h02A, 2, tk);
        sb.push_back(9'h055);
        sb.push_back(9'h02A);
        for (int f = 0; f < 2; f++) begin
            wait_rx(r, got);
            e = frame_bits(sb.pop_front(), 7, 0);
            if (f == 0) t_first = r.t0;
            checks++;
            if (!got || !r.ok || (r.bits & mask(10)) !== (e & mask(10)) || r.bits[9:8] !== 2'b11 ||
                r.t0 != tk + 15 + time'(f) * 400) begin
                failures++;
                $display("FAIL two_stop_frame%0d got=%b ok=%b bits=%b t0=%0t expected bits=%b t0=%0t",
                         f, got, r.ok, r.bits & mask(10), r.t0, e & mask(10), tk + 15 + time'(f) * 400);
            end
        end
        checks++;
        if (r.t0 - t_first != 400) begin
            failures++;
            $display("FAIL two_stop_gap got=%0t expected 400", r.t0 - t_first);
        end
        wait_all_idle("two_stop");
    endtask

    task automatic test_reset_mid_frame;
        time         tk;
        rx_t         r;
        bit          got;
        int          bad = 0;
        logic [8:0]  w = 9'h034;
        logic [11:0] e;
        mon_sel = 0; mon_bits = 10; rxq.delete(); sb.delete();
        push_words(w, 9'h05A, 2, tk);
        checks++;
        if (if0.level_o !== 3'd1) begin
            failures++;
            $display("FAIL midrst_level_before got=%0d expected 1", if0.level_o);
        end
        repeat (17) @(negedge CLK);
        checks++;
        if (sig[0] !== w[3]) begin
            failures++;
            $display("FAIL midrst_data_bit3 got=%b expected %b", sig[0], w[3]);
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (sig[0] !== 1'b1 || if0.level_o !== 3'd0 || if0.waitflg !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after_reset line=%b level=%0d wait=%b expected 1 0 0",
                     sig[0], if0.level_o, if0.waitflg);
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (60) begin
            @(negedge CLK);
            if (sig[0] !== 1'b1 || if0.waitflg !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || rxq.size() != 0) begin
            failures++;
            $display("FAIL midrst_quiet bad_cycles=%0d frames=%0d expected 0 0", bad, rxq.size());
        end
        push_words(9'h0C3, 9'h000, 1, tk);
        sb.push_back(9'h0C3);
        wait_rx(r, got);
        e = frame_bits(sb.pop_front(), 8, 0);
        checks++;
        if (!got || !r.ok || (r.bits & mask(10)) !== (e & mask(10)) || r.t0 != tk + 15) begin
            failures++;
            $display("FAIL midrst_next_frame got=%b ok=%b bits=%b t0=%0t expected bits=%b t0=%0t",
                     got, r.ok, r.bits & mask(10), r.t0, e & mask(10), tk + 15);
        end
        wait_all_idle("midrst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity(1, 2);
        test_parity(2, 1);
        test_back_to_back();
        test_two_stop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
